// File: rtl/gb_serial_link_if.sv
// CPU-side register bus for the Game Boy link port: SB/SC selects, write strobe, read data and
// the transfer-complete interrupt pulse.
interface gb_serial_link_if;
    logic       cpu_sel_sb;
    logic       cpu_sel_sc;
    logic       cpu_wr;
    logic [7:0] cpu_di;
    logic [7:0] cpu_do;
    logic       irq;

    modport master (
        output cpu_sel_sb,
        output cpu_sel_sc,
        output cpu_wr,
        output cpu_di,
        input  cpu_do,
        input  irq
    );

    modport slave (
        input  cpu_sel_sb,
        input  cpu_sel_sc,
        input  cpu_wr,
        input  cpu_di,
        output cpu_do,
        output irq
    );
endinterface

// File: rtl/gb_serial_link.sv
// Game Boy link port behind SB/SC: internal-clock master or external-clock slave, MSB-first.
// Define SERIAL_CGB_FAST_EN to make SC[1] a writable CGB fast-clock bit (32x internal rate).
module gb_serial_link #(
    parameter int unsigned CLK_DIV     = 512,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    gb_serial_link_if.slave cpu,
    input  logic            ser_clk_in,
    input  logic            ser_data_in,
    output logic            ser_clk_out,
    output logic            ser_clk_oe,
    output logic            ser_data_out
);

    localparam int unsigned HalfSlow = CLK_DIV / 2;
    localparam int unsigned DivW     = (HalfSlow > 1) ? $clog2(HalfSlow) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StXferInt,
        StXferExt
    } state_e;

    state_e state_q, state_d;

    logic [7:0]      sb_q, sb_d;
    logic            sc_clk_q, sc_clk_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [DivW-1:0] div_q, div_d;
    logic            sck_out_q, sck_out_d;
    logic            sout_q, sout_d;
    logic            irq_q, irq_d;
    logic            wr_q;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] sin_sync_q;
    logic                   sck_edge_q;

    logic            wr_rise, sb_wr, sc_wr;
    logic            sck_s, sin_s, ext_rise, ext_fall;
    logic            bit_done, sc_start, sc_bit1;
    logic            do_fall, do_rise;
    logic [DivW-1:0] half_m1;

`ifdef SERIAL_CGB_FAST_EN
    localparam int unsigned HalfFast = (CLK_DIV / 64 > 0) ? CLK_DIV / 64 : 1;

    logic sc_fast_q, sc_fast_d;

    assign sc_bit1 = sc_fast_q;
    assign half_m1 = sc_fast_q ? DivW'(HalfFast - 1) : DivW'(HalfSlow - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sc_fast_q <= 1'b0;
        end else begin
            sc_fast_q <= sc_fast_d;
        end
    end

    always_comb begin
        sc_fast_d = sc_fast_q;
        if (sc_wr) begin
            sc_fast_d = cpu.cpu_di[1];
        end
    end
`else
    assign sc_bit1 = 1'b1;
    assign half_m1 = DivW'(HalfSlow - 1);
`endif

    // Writes act once per strobe rising edge; cpu_wr may be held for several cycles.
    assign wr_rise = cpu.cpu_wr & ~wr_q;
    assign sb_wr   = wr_rise & cpu.cpu_sel_sb;
    assign sc_wr   = wr_rise & cpu.cpu_sel_sc;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sin_s    = sin_sync_q[SYNC_STAGES-1];
    assign ext_rise = sck_s & ~sck_edge_q;
    assign ext_fall = ~sck_s & sck_edge_q;

    assign bit_done = (bitcnt_q == 4'd8);
    assign sc_start = (state_q != StIdle);

    // Peer clock and data idle high, so the synchronisers reset high to avoid a phantom edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q <= '1;
            sin_sync_q <= '1;
            sck_edge_q <= 1'b1;
            wr_q       <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], ser_clk_in};
            sin_sync_q <= {sin_sync_q[SYNC_STAGES-2:0], ser_data_in};
            sck_edge_q <= sck_s;
            wr_q       <= cpu.cpu_wr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sc_wr) begin
            if (cpu.cpu_di[7]) begin
                state_d = cpu.cpu_di[0] ? StXferInt : StXferExt;
            end else begin
                state_d = StIdle;
            end
        end else if (sc_start && bit_done) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        sb_d      = sb_q;
        sc_clk_d  = sc_clk_q;
        bitcnt_d  = bitcnt_q;
        div_d     = div_q;
        sck_out_d = sck_out_q;
        sout_d    = sout_q;
        irq_d     = 1'b0;
        do_fall   = 1'b0;
        do_rise   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sb_wr) begin
                    sb_d = cpu.cpu_di;
                end
            end
            StXferInt: begin
                if (!bit_done) begin
                    if (div_q == half_m1) begin
                        div_d     = '0;
                        sck_out_d = ~sck_out_q;
                        do_fall   = sck_out_q;
                        do_rise   = ~sck_out_q;
                    end else begin
                        div_d = div_q + DivW'(1);
                    end
                end else begin
                    irq_d = 1'b1;
                end
            end
            StXferExt: begin
                if (!bit_done) begin
                    do_fall = ext_fall;
                    do_rise = ext_rise;
                end else begin
                    irq_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (do_fall) begin
            sout_d = sb_q[7];
        end
        if (do_rise) begin
            sb_d     = {sb_q[6:0], sin_s};
            bitcnt_d = bitcnt_q + 4'd1;
        end

        // An SC write beats a same-cycle shift or completion; the partial byte is kept.
        if (sc_wr) begin
            sc_clk_d  = cpu.cpu_di[0];
            bitcnt_d  = 4'd0;
            div_d     = '0;
            sck_out_d = 1'b1;
            irq_d     = 1'b0;
            if (sc_start) begin
                sb_d = sb_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_q      <= 8'h00;
            sc_clk_q  <= 1'b0;
            bitcnt_q  <= 4'd0;
            div_q     <= '0;
            sck_out_q <= 1'b1;
            sout_q    <= 1'b1;
            irq_q     <= 1'b0;
        end else begin
            sb_q      <= sb_d;
            sc_clk_q  <= sc_clk_d;
            bitcnt_q  <= bitcnt_d;
            div_q     <= div_d;
            sck_out_q <= sck_out_d;
            sout_q    <= sout_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        cpu.cpu_do = 8'hFF;
        if (cpu.cpu_sel_sb) begin
            cpu.cpu_do = sb_q;
        end else if (cpu.cpu_sel_sc) begin
            cpu.cpu_do = {sc_start, 5'h1F, sc_bit1, sc_clk_q};
        end
    end

    assign cpu.irq      = irq_q;
    assign ser_clk_out  = sck_out_q;
    assign ser_clk_oe   = sc_clk_q;
    assign ser_data_out = sout_q;

endmodule
